// File: rtl/gain_fanout8_axis.sv
// gain_fanout8_axis
// One signed sample stream fanned out to eight gain lanes. Each accepted
// sample is multiplied by eight programmable signed gains, scaled back to
// DATA_WIDTH, saturated, and emitted as one packed beat {y7,...,y0}.
// Gains are double-buffered (shadow/active) and snapshotted at input
// acceptance, so every beat uses one consistent gain set.
// Optional feature macro: GAIN_FANOUT8_ROUND_EN
//   defined   -> round-half-up scaling (rounding adder in stage 3)
//   undefined -> arithmetic-shift truncation
module gain_fanout8_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int GAIN_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [8*DATA_WIDTH-1:0]   m_axis_tdata,
    input  logic                      gain_wr_en,
    input  logic [2:0]                gain_wr_addr,
    input  logic [GAIN_WIDTH-1:0]     gain_wr_data,
    input  logic                      gain_commit
);

    localparam int LANES = 8;
    localparam int PW    = DATA_WIDTH + GAIN_WIDTH;
    localparam int SH    = GAIN_WIDTH - 1;

    // Output range expressed at product width so the shifted value can be
    // compared directly before narrowing.
    localparam logic signed [PW-1:0] SAT_MAX =
        {{(PW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN =
        {{(PW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

`ifdef GAIN_FANOUT8_ROUND_EN
    // Half an output LSB at product scale: 2^(GAIN_WIDTH-2).
    localparam logic signed [PW-1:0] RND_HALF =
        {{(PW-GAIN_WIDTH+1){1'b0}}, 1'b1, {(GAIN_WIDTH-2){1'b0}}};

    // Round half up. Cannot overflow: |p| <= 2^(PW-2).
    function automatic logic signed [PW-1:0] round_fn(input logic signed [PW-1:0] p);
        return p + RND_HALF;
    endfunction
`endif

    // Shift back to Q1.(DATA_WIDTH-1) and clamp; only (-1)*(-1) overflows.
    function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        s = p >>> SH;
        if (s > SAT_MAX) begin
            sat_fn = SAT_MAX[DATA_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            sat_fn = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_fn = s[DATA_WIDTH-1:0];
        end
    endfunction

    logic signed [GAIN_WIDTH-1:0] shadow_q [LANES];
    logic signed [GAIN_WIDTH-1:0] active_q [LANES];

    logic                         vld_p1_q;
    logic signed [DATA_WIDTH-1:0] x_p1_q;
    logic signed [GAIN_WIDTH-1:0] g_p1_q [LANES];

    logic                         vld_p2_q;
    logic signed [PW-1:0]         prod_p2_d [LANES];
    logic signed [PW-1:0]         prod_p2_q [LANES];

    logic                         tvalid_q;
    logic [8*DATA_WIDTH-1:0]      tdata_d;
    logic [8*DATA_WIDTH-1:0]      tdata_q;

    logic                         can_load;

    // The whole pipeline moves only when the output register may be overwritten.
    assign can_load      = ~tvalid_q | m_axis_tready;
    assign s_axis_tready = can_load;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;

    // Gain banks: writes land in shadow; commit copies shadow to active,
    // forwarding a same-cycle write so it is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LANES; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            if (gain_wr_en) begin
                shadow_q[gain_wr_addr] <= gain_wr_data;
            end
            if (gain_commit) begin
                for (int k = 0; k < LANES; k++) begin
                    if (gain_wr_en && (gain_wr_addr == 3'(k))) begin
                        active_q[k] <= gain_wr_data;
                    end else begin
                        active_q[k] <= shadow_q[k];
                    end
                end
            end
        end
    end

    // ---- stage 1: capture sample and snapshot of the active gains ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            x_p1_q   <= '0;
            for (int k = 0; k < LANES; k++) begin
                g_p1_q[k] <= '0;
            end
        end else if (can_load) begin
            vld_p1_q <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                x_p1_q <= s_axis_tdata;
                for (int k = 0; k < LANES; k++) begin
                    g_p1_q[k] <= active_q[k];
                end
            end
        end
    end

    // ---- stage 2: full-precision signed products ----
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            prod_p2_d[k] = PW'(x_p1_q) * PW'(g_p1_q[k]);
        end
    end

    // Register the eight products alongside the stage valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                prod_p2_q[k] <= '0;
            end
        end else if (can_load) begin
            vld_p2_q <= vld_p1_q;
            for (int k = 0; k < LANES; k++) begin
                prod_p2_q[k] <= prod_p2_d[k];
            end
        end
    end

    // ---- stage 3: scale, saturate and pack into the output beat ----
    always_comb begin
        tdata_d = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef GAIN_FANOUT8_ROUND_EN
            tdata_d[k*DATA_WIDTH +: DATA_WIDTH] = sat_fn(round_fn(prod_p2_q[k]));
`else
            tdata_d[k*DATA_WIDTH +: DATA_WIDTH] = sat_fn(prod_p2_q[k]);
`endif
        end
    end

    // Output register: a new beat loads over a consumed one; otherwise a
    // consumed beat clears valid and a stalled beat holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else if (can_load && vld_p2_q) begin
            tvalid_q <= 1'b1;
            tdata_q  <= tdata_d;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end

endmodule
